// File: rtl/vga_timing_out_if.sv
// Pixel bus between the VGA timing back-end and the drawer/mux pipeline.
// Carries pixel coordinates and frame strobe out, the mux colour in, and the VGA pins out.
// master: the timing generator (vga_timing_out); slave: the drawer/mux side and the VGA pins.
interface vga_timing_out_if;
  logic [7:0]  RGBIn;      // {R[2:0],G[2:0],B[1:0]} from the objects mux
  logic [10:0] pixelX;     // current horizontal count
  logic [10:0] pixelY;     // current vertical count
  logic        frameTick;  // one clock at the start of vertical blanking
  logic [7:0]  vgaR;
  logic [7:0]  vgaG;
  logic [7:0]  vgaB;
  logic        vgaHS;      // active low
  logic        vgaVS;      // active low
  logic        vgaBlankN;  // high while the output pixel is visible

  modport master (
    input  RGBIn,
    output pixelX, pixelY, frameTick, vgaR, vgaG, vgaB, vgaHS, vgaVS, vgaBlankN
  );

  modport slave (
    output RGBIn,
    input  pixelX, pixelY, frameTick, vgaR, vgaG, vgaB, vgaHS, vgaVS, vgaBlankN
  );
endinterface

// File: rtl/vga_timing_out.sv
// Purpose: 640x480@60 VGA timing generator; expands the 8-bit mux pixel to 24-bit colour.
// Latency: counter state at edge t reaches sync/blank/colour outputs at edge t+PIPE_DELAY+1.
// Backpressure: none, free-running pixel stream; RGBIn must arrive PIPE_DELAY clocks after pixelX/Y.
// Ports: clk (pixel clock), resetN (async active-low), bus (vga_timing_out_if.master):
//   RGBIn in; pixelX/pixelY/frameTick to the drawers; vgaR/G/B, vgaHS, vgaVS, vgaBlankN to the pins.
module vga_timing_out #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int PIPE_DELAY = 2
) (
  input  logic             clk,
  input  logic             resetN,
  vga_timing_out_if.master bus
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  // Delay-line word is {active, hs_n, vs_n}; idle means blanked with both syncs released.
  localparam logic [2:0] IDLE_SIG = 3'b011;

  // ---------------------------------------------------------------- counters
  logic [10:0] h_cnt_q, h_cnt_d;
  logic [10:0] v_cnt_q, v_cnt_d;
  logic        frame_tick_q, frame_tick_d;
  logic        h_wrap;

  always_comb begin
    h_wrap  = (h_cnt_q == 11'(H_TOTAL - 1));
    h_cnt_d = h_wrap ? 11'd0 : h_cnt_q + 11'd1;
    v_cnt_d = v_cnt_q;
    if (h_wrap) begin
      v_cnt_d = (v_cnt_q == 11'(V_TOTAL - 1)) ? 11'd0 : v_cnt_q + 11'd1;
    end
    // Computed from the next counter values so the strobe is registered with them.
    frame_tick_d = (h_cnt_d == 11'd0) && (v_cnt_d == 11'(V_ACTIVE));
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      h_cnt_q      <= '0;
      v_cnt_q      <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      h_cnt_q      <= h_cnt_d;
      v_cnt_q      <= v_cnt_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  // ------------------------------------------------- timing from counters
  logic       act_now, hs_n_now, vs_n_now;
  logic [2:0] sig_now, sig_dly;

  always_comb begin
    act_now  = (h_cnt_q < 11'(H_ACTIVE)) && (v_cnt_q < 11'(V_ACTIVE));
    hs_n_now = !((h_cnt_q >= 11'(HS_START)) && (h_cnt_q < 11'(HS_END)));
    vs_n_now = !((v_cnt_q >= 11'(VS_START)) && (v_cnt_q < 11'(VS_END)));
    sig_now  = {act_now, hs_n_now, vs_n_now};
  end

  // ---------------------------------------------------------- delay line
  // Matches the drawer + mux register depth so sync/blank line up with RGBIn.
  generate
    if (PIPE_DELAY == 0) begin : g_no_dly
      assign sig_dly = sig_now;
    end else begin : g_dly
      logic [PIPE_DELAY-1:0][2:0] pipe_q, pipe_d;

      always_comb begin
        pipe_d[0] = sig_now;
        for (int i = 1; i < PIPE_DELAY; i++) begin
          pipe_d[i] = pipe_q[i-1];
        end
      end

      always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
          pipe_q <= {PIPE_DELAY{IDLE_SIG}};
        end else begin
          pipe_q <= pipe_d;
        end
      end

      assign sig_dly = pipe_q[PIPE_DELAY-1];
    end
  endgenerate

  // -------------------------------------------------------- output stage
  logic [7:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic       hs_n_q, hs_n_d, vs_n_q, vs_n_d, blank_n_q, blank_n_d;

  always_comb begin
    r_d       = '0;
    g_d       = '0;
    b_d       = '0;
    blank_n_d = sig_dly[2];
    hs_n_d    = sig_dly[1];
    vs_n_d    = sig_dly[0];
    // Bit replication spreads each field over the full 8-bit range (7 -> FF, 0 -> 00).
    if (sig_dly[2]) begin
      r_d = {bus.RGBIn[7:5], bus.RGBIn[7:5], bus.RGBIn[7:6]};
      g_d = {bus.RGBIn[4:2], bus.RGBIn[4:2], bus.RGBIn[4:3]};
      b_d = {4{bus.RGBIn[1:0]}};
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
      hs_n_q    <= 1'b1;
      vs_n_q    <= 1'b1;
      blank_n_q <= 1'b0;
    end else begin
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
      hs_n_q    <= hs_n_d;
      vs_n_q    <= vs_n_d;
      blank_n_q <= blank_n_d;
    end
  end

  assign bus.pixelX    = h_cnt_q;
  assign bus.pixelY    = v_cnt_q;
  assign bus.frameTick = frame_tick_q;
  assign bus.vgaR      = r_q;
  assign bus.vgaG      = g_q;
  assign bus.vgaB      = b_q;
  assign bus.vgaHS     = hs_n_q;
  assign bus.vgaVS     = vs_n_q;
  assign bus.vgaBlankN = blank_n_q;

endmodule

// File: tb/tb_vga_timing_out.sv
// Bench for vga_timing_out: full horizontal timing, vertical span shortened so two frames fit.
// Every clock is compared against a cycle-count model; timing and colour cases are checked directly.
module tb_vga_timing_out;
  localparam int HA = 640, HF = 16, HS = 96, HB = 48;
  localparam int VA = 6, VF = 2, VS = 2, VB = 3;
  localparam int PD = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic clk = 1'b0;
  logic resetN;
  vga_timing_out_if bus ();

  vga_timing_out #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .PIPE_DELAY(PD)
  ) dut (
    .clk(clk),
    .resetN(resetN),
    .bus(bus)
  );

  always #20 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int k;  // clock edges since the last reset release

  // measurement state
  logic prev_hs, prev_vs, prev_blank;
  logic [10:0] prev_px, prev_py;
  int k656, hs_fall, hs_len, hs_delay, line_period;
  int blank_rise, blank_len, vs_fall, vs_len, frame_period;
  int ft_count, align_hits, align_k;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at k=%0d: observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  function automatic logic [49:0] observed();
    return {bus.pixelX, bus.pixelY, bus.frameTick, bus.vgaR, bus.vgaG, bus.vgaB,
            bus.vgaHS, bus.vgaVS, bus.vgaBlankN};
  endfunction

  // Expected outputs after edge n, given the colour sampled on that edge.
  function automatic logic [49:0] model(input int n, input logic [7:0] rgb);
    int h, v, s, hh, vv, ri, gi, bi;
    logic ft, act, hs, vs;
    logic [7:0] r, g, b;
    h  = n % HT;
    v  = (n / HT) % VT;
    ft = (h == 0) && (v == VA);
    act = 1'b0; hs = 1'b1; vs = 1'b1;
    if (n >= PD + 1) begin
      s   = n - PD - 1;
      hh  = s % HT;
      vv  = (s / HT) % VT;
      act = (hh < HA) && (vv < VA);
      hs  = !((hh >= HA + HF) && (hh < HA + HF + HS));
      vs  = !((vv >= VA + VF) && (vv < VA + VF + VS));
    end
    ri = int'(rgb[7:5]); gi = int'(rgb[4:2]); bi = int'(rgb[1:0]);
    // Scale each field to 0..255 with rounding.
    r = act ? 8'((ri * 255 + 3) / 7) : 8'd0;
    g = act ? 8'((gi * 255 + 3) / 7) : 8'd0;
    b = act ? 8'(bi * 85) : 8'd0;
    return {11'(h), 11'(v), ft, r, g, b, hs, vs, act};
  endfunction

  task automatic clear_meas();
    prev_hs = 1'b1; prev_vs = 1'b1; prev_blank = 1'b0;
    prev_px = '0; prev_py = '0;
    k656 = -1; hs_fall = -1; hs_len = 0; hs_delay = 0; line_period = 0;
    blank_rise = -1; blank_len = 0; vs_fall = -1; vs_len = 0; frame_period = 0;
    ft_count = 0; align_hits = 0; align_k = 0;
  endtask

  task automatic step(input logic [7:0] rgb);
    bus.RGBIn = rgb;
    @(posedge clk);
    k++;
    #1;
    chk("cycle", 64'(observed()), 64'(model(k, rgb)));
    if (bus.pixelX == 11'(HA + HF)) k656 = k;
    if (prev_hs && !bus.vgaHS) begin
      hs_delay = k - k656;
      if (hs_fall >= 0) line_period = k - hs_fall;
      hs_fall = k;
    end
    if (!prev_hs && bus.vgaHS) hs_len = k - hs_fall;
    if (!prev_blank && bus.vgaBlankN) blank_rise = k;
    if (prev_blank && !bus.vgaBlankN && blank_rise >= 0) blank_len = k - blank_rise;
    if (prev_vs && !bus.vgaVS) begin
      if (vs_fall >= 0) frame_period = k - vs_fall;
      vs_fall = k;
    end
    if (!prev_vs && bus.vgaVS) vs_len = k - vs_fall;
    if (bus.frameTick) ft_count++;
    if ((k / HT) == 2 && bus.vgaR != 8'd0) begin
      align_hits++;
      align_k = k;
    end
    if (k % FT == 0) begin
      chk("wrap_now", 64'({bus.pixelX, bus.pixelY}), 64'(0));
      chk("wrap_prev", 64'({prev_px, prev_py}), 64'({11'(HT - 1), 11'(VT - 1)}));
      chk("wrap_vs", 64'(bus.vgaVS), 64'(1));
    end
    prev_hs = bus.vgaHS; prev_vs = bus.vgaVS; prev_blank = bus.vgaBlankN;
    prev_px = bus.pixelX; prev_py = bus.pixelY;
  endtask

  initial begin
    logic [7:0] rgb;
    logic [49:0] rst_vec;
    rst_vec = model(0, 8'h00);
    resetN = 1'b0;
    bus.RGBIn = 8'h00;
    k = 0;
    clear_meas();

    // Power-on reset
    repeat (3) @(posedge clk);
    #1;
    chk("reset_values", 64'(observed()), 64'(rst_vec));
    resetN = 1'b1;

    // Random pixels through the first lines
    for (int i = 0; i < 1000; i++) step(8'($urandom_range(0, 255)));

    // Asynchronous reset mid-line, no clock edge needed
    resetN = 1'b0;
    #1;
    chk("async_reset", 64'(observed()), 64'(rst_vec));
    @(posedge clk);
    #1;
    chk("reset_hold", 64'(observed()), 64'(rst_vec));
    resetN = 1'b1;
    k = 0;
    clear_meas();
    step(8'($urandom_range(0, 255)));
    chk("restart_px1", 64'(bus.pixelX), 64'(1));
    step(8'($urandom_range(0, 255)));
    chk("restart_px2", 64'(bus.pixelX), 64'(2));
    step(8'($urandom_range(0, 255)));
    chk("restart_px3", 64'(bus.pixelX), 64'(3));

    // Two full frames plus three lines
    while (k < 2 * FT + 3 * HT) begin
      if (((k + 1) / HT) == 2)
        rgb = (((k + 1 - PD - 1) % HT) == 5) ? 8'hFF : 8'h00;  // single-pixel alignment probe
      else if (((k + 1) / HT) == 3)
        rgb = (bus.pixelX >= 11'(HA)) ? 8'hFF : 8'h00;        // white during blanking
      else
        rgb = 8'($urandom_range(0, 255));
      step(rgb);
    end

    // Move into active video of the next line, then directed colours
    repeat (10) step(8'h00);
    step(8'hE0);
    chk("red_full", 64'({bus.vgaR, bus.vgaG, bus.vgaB}), 64'(24'hFF0000));
    step(8'h1C);
    chk("green_full", 64'({bus.vgaR, bus.vgaG, bus.vgaB}), 64'(24'h00FF00));
    step(8'h03);
    chk("blue_full", 64'({bus.vgaR, bus.vgaG, bus.vgaB}), 64'(24'h0000FF));
    step(8'h92);
    chk("mix_92", 64'({bus.vgaR, bus.vgaG, bus.vgaB}), 64'(24'h9292AA));

    // Timing measurements
    chk("hs_len", 64'(hs_len), 64'(HS));
    chk("hs_delay", 64'(hs_delay), 64'(PD + 1));
    chk("line_period", 64'(line_period), 64'(HT));
    chk("blank_len", 64'(blank_len), 64'(HA));
    chk("vs_len", 64'(vs_len), 64'(VS * HT));
    chk("frame_period", 64'(frame_period), 64'(FT));
    chk("frame_ticks", 64'(ft_count), 64'(2));
    chk("align_hits", 64'(align_hits), 64'(1));
    chk("align_pos", 64'(align_k % HT), 64'(5 + PD + 1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vga_timing_out.md
Name: vga_timing_out

Overview:
- Display back-end of the billiard screen pipeline. Generates 640x480@60 VGA timing from a 25 MHz pixel clock.
- Drives pixelX/pixelY to all object drawers (balls, hole number, holes, borders, board).
- Consumes the 8-bit RRRGGGBB pixel from the objects mux and expands it to 24-bit VGA colour.
- Delays sync and blank so they stay cycle-aligned with the colour data returned by the drawer/mux pipeline.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, horizontal sync width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
PIPE_DELAY, 2, clocks from pixelX/pixelY output to the matching RGBIn value (drawer register + mux register)

Ports:
clk  input  1  pixel clock, 25 MHz
resetN  input  1  asynchronous active-low reset
RGBIn  input  8  pixel from objects mux, {R[2:0],G[2:0],B[1:0]}
pixelX  output  11  current horizontal count (0..H_TOTAL-1)
pixelY  output  11  current vertical count (0..V_TOTAL-1)
frameTick  output  1  one-clock pulse at start of vertical blanking (game/physics update strobe)
vgaR  output  8  red
vgaG  output  8  green
vgaB  output  8  blue
vgaHS  output  1  horizontal sync, active low
vgaVS  output  1  vertical sync, active low
vgaBlankN  output  1  high while output pixel is visible

Behaviour:
- Single clock domain (clk); reset asynchronous, active-low (resetN).
- Line and frame lengths: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800; V_TOTAL = 525.
- Horizontal counter hCount: increments every clk and wraps H_TOTAL-1 -> 0.
- Vertical counter vCount: increments only on the hCount wrap; wraps V_TOTAL-1 -> 0 on the same edge that hCount wraps.
- pixelX = hCount and pixelY = vCount, both registered. They are valid through blanking, and drawers must ignore them there.
- Internal active = (hCount < H_ACTIVE) && (vCount < V_ACTIVE).
- Internal hsN is low when H_ACTIVE+H_FP <= hCount < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751.
- Internal vsN is low when vCount is in 490..491, evaluated combinationally from the registered counters.
- frameTick = 1 for exactly the one clock where hCount==0 and vCount==V_ACTIVE. It is registered alongside the counters, not delayed.
- Delay line: active, hsN and vsN pass through a PIPE_DELAY-stage shift register.
- Output stage: one further register stage.
  - vgaHS, vgaVS and vgaBlankN take the delayed values.
  - If delayed active: vgaR = {R,R,R[2:1]}, vgaG = {G,G,G[2:1]}, vgaB = {B,B,B,B} (bit replication).
  - Otherwise vgaR, vgaG and vgaB = 0.
- Total latency: counter state at edge t appears on the sync/blank outputs at edge t+PIPE_DELAY+1. The colour sampled from RGBIn at edge t+PIPE_DELAY+1 appears on the same edge.
- Reset values:
  - hCount, vCount, pixelX and pixelY: 0.
  - frameTick: 0.
  - vgaR, vgaG, vgaB: 0.
  - vgaBlankN: 0.
  - vgaHS, vgaVS: 1.
  - All delay stages: inactive (active=0, hsN=1, vsN=1).
- Reset asserted mid-frame: all of the above take their reset values immediately (asynchronous). After release, counting restarts from (0,0) on the first clk edge, with no partial sync pulse emitted.
- RGBIn is ignored while delayed active = 0, whatever its value.
- PIPE_DELAY = 0 is legal and gives a direct path into the output register.

Test Plan:
- Reset: hold resetN=0 mid-line -> all outputs at reset values within the same cycle; release -> pixelX counts 1,2,3 on consecutive edges.
- Horizontal timing: run one line -> vgaHS low for exactly 96 clocks, falling 3 clocks after pixelX reaches 656; line period 800 clocks; vgaBlankN high for 640 clocks per visible line.
- Vertical timing and frameTick: run two frames -> frame period 420000 clocks; vgaVS low for 1600 clocks; frameTick high exactly once per frame, when pixelX=0, pixelY=480.
- Colour expansion during active video:
  - RGBIn=8'hE0 -> R=FF, G=00, B=00.
  - RGBIn=8'h1C -> G=FF.
  - RGBIn=8'h03 -> B=FF.
  - RGBIn=8'h92 -> R=92, G=92, B=AA.
- Alignment and blanking:
  - Drive RGBIn=8'hFF only on the cycle whose pixelX=5 occurred 2 clocks earlier -> vgaR=FF on exactly the one clock where the delayed pixel 5 is output.
  - Drive RGBIn=8'hFF while pixelX is 640..799 -> vgaR/vgaG/vgaB stay 0.
- Wrap-around: observe the transition pixelX 799->0 with pixelY 524->0 on the same edge; vgaVS is not asserted across the wrap.
